// File: rtl/ntt_sched.sv
// ntt_sched: address/control sequencer for a single Kyber butterfly unit running
// an in-place forward NTT (op=0) or inverse NTT (op=1) over one 256-coefficient
// polynomial RAM.
//
// Each run issues 7 layers of 128 butterflies. Within a layer there is one
// butterfly per cycle with no bubbles. Between layers, PIPE = RD_LAT + BU_LAT
// idle cycles let the last write of a layer retire before the next layer reads.
// Write addresses are the read addresses delayed by PIPE cycles.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, op             run request (sampled only when idle) and NTT/INTT select
//   busy, done            run in progress / one-cycle completion pulse
//   rd_en                 read both RAM ports this cycle
//   rd_addr_u, rd_addr_t  u operand (j) and t operand (j+len) addresses
//   zeta_addr             twiddle ROM index, valid with rd_en
//   bu_mode               butterfly mode: 0 = CT (NTT), 1 = GS (INTT)
//   wr_en                 write BU outputs back
//   wr_addr_u, wr_addr_t  write-back addresses (delayed read addresses)
module ntt_sched #(
  parameter int RD_LAT = 1,
  parameter int BU_LAT = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_u,
  output logic [7:0] rd_addr_t,
  output logic [6:0] zeta_addr,
  output logic [1:0] bu_mode,
  output logic       wr_en,
  output logic [7:0] wr_addr_u,
  output logic [7:0] wr_addr_t
);

  localparam int PIPE  = RD_LAT + BU_LAT;
  localparam int CNT_W = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE - 1);
  localparam int DL_W  = 17;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_op;
  logic [2:0]       r_layer;
  logic [6:0]       r_b;
  logic [CNT_W-1:0] r_cnt;

  logic             w_issue;
  logic             w_busy;
  logic             w_done;
  logic             w_last_b;
  logic             w_last_cnt;
  logic             w_last_layer;

  logic [2:0]       w_lg;
  logic [3:0]       w_lg1;
  logic [7:0]       w_b8;
  logic [7:0]       w_len;
  logic [7:0]       w_g;
  logic [7:0]       w_off;
  logic [7:0]       w_j;
  logic [6:0]       w_zeta;
  logic [7:0]       w_addr_u;
  logic [7:0]       w_addr_t;
  logic [6:0]       w_zeta_g;

  logic [DL_W-1:0]  r_dl_p [PIPE];

  assign w_last_b     = (r_b == 7'd127);
  assign w_last_cnt   = (r_cnt == CNT_LAST);
  assign w_last_layer = (r_layer == 3'd6);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_last_b) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_cnt) w_state_nxt = w_last_layer ? S_DONE : S_ISSUE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_issue = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_ISSUE: begin w_issue = 1'b1; w_busy = 1'b1; end
      S_DRAIN: w_busy = 1'b1;
      S_DONE:  begin w_busy = 1'b1; w_done = 1'b1; end
      default: ;
    endcase
  end

  // Layer / butterfly / drain counters; op is captured only when a run starts,
  // so bu_mode cannot change mid-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 1'b0;
      r_layer <= 3'd0;
      r_b     <= 7'd0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_layer <= 3'd0;
            r_b     <= 7'd0;
            r_cnt   <= '0;
          end
        end
        S_ISSUE: r_b <= r_b + 7'd1;  // wraps to 0 after 127, ready for next layer
        S_DRAIN: begin
          if (w_last_cnt) begin
            r_cnt   <= '0;
            r_layer <= r_layer + 3'd1;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Address generation. lg = log2(len): NTT halves len each layer, INTT doubles it.
  // j inserts a zero bit at position lg into b, which selects the lower half of
  // each 2*len block; t sits len above it.
  always_comb begin
    w_lg     = r_op ? (r_layer + 3'd1) : (3'd7 - r_layer);
    w_lg1    = {1'b0, w_lg} + 4'd1;
    w_b8     = {1'b0, r_b};
    w_len    = 8'd1 << w_lg;
    w_g      = w_b8 >> w_lg;
    w_off    = w_b8 & (w_len - 8'd1);
    w_j      = (w_g << w_lg1) | w_off;
    w_zeta_g = w_g[6:0];
    // Forward twiddles ascend 1..127 across the run, inverse ones descend 127..1.
    if (r_op) w_zeta = 7'((9'd256 >> w_lg) - 9'd1 - {2'b00, w_zeta_g});
    else      w_zeta = 7'((8'd128 >> w_lg) + {1'b0, w_zeta_g});
  end

  // Addresses are forced to zero outside ISSUE so idle outputs stay quiet.
  assign w_addr_u = w_issue ? w_j : 8'd0;
  assign w_addr_t = w_issue ? (w_j + w_len) : 8'd0;

  // Write-back delay line: matches RAM read latency plus BU latency. Cleared on
  // reset so writes in flight are dropped immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) r_dl_p[i] <= '0;
    end else begin
      r_dl_p[0] <= {w_issue, w_addr_u, w_addr_t};
      for (int i = 1; i < PIPE; i++) r_dl_p[i] <= r_dl_p[i-1];
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign rd_en     = w_issue;
  assign rd_addr_u = w_addr_u;
  assign rd_addr_t = w_addr_t;
  assign zeta_addr = w_issue ? w_zeta : 7'd0;
  assign bu_mode   = {1'b0, r_op};
  assign {wr_en, wr_addr_u, wr_addr_t} = r_dl_p[PIPE-1];

endmodule

// File: tb/tb_ntt_sched.sv
// Bench for ntt_sched: a scoreboard built from the textbook Kyber NTT/INTT
// loop nests, plus a behavioural BU + RAM + zeta ROM model that carries real
// coefficient data through the schedule.
module tb_ntt_sched;

  localparam int PIPE      = 6;
  localparam int LAYER_CYC = 128 + PIPE;
  localparam int RUN_CYC   = 7 * LAYER_CYC + 1;  // start accept -> done
  localparam int Q         = 3329;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_addr_u, rd_addr_t, wr_addr_u, wr_addr_t;
  logic [6:0] zeta_addr;
  logic [1:0] bu_mode;

  ntt_sched #(.RD_LAT(1), .BU_LAT(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_u(rd_addr_u), .rd_addr_t(rd_addr_t), .zeta_addr(zeta_addr),
    .bu_mode(bu_mode), .wr_en(wr_en), .wr_addr_u(wr_addr_u), .wr_addr_t(wr_addr_t)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int u; int t; int z; int mode; } rd_exp_t;
  typedef struct { int cyc; int u; int t; } wr_exp_t;
  typedef struct { int u; int t; } bu_res_t;
  typedef struct { int lo; int hi; } iv_t;

  rd_exp_t rdq[$];
  wr_exp_t wrq[$];
  int      doneq[$];
  bu_res_t buq[$];
  iv_t     busyq[$];

  int ram  [256];
  int orig [256];
  int refp [256];
  int zt   [128];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int cur_op = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic longint all_outs();
    return longint'({busy, done, rd_en, rd_addr_u, rd_addr_t, zeta_addr,
                     bu_mode, wr_en, wr_addr_u, wr_addr_t});
  endfunction

  function automatic int busy_exp(input int c);
    foreach (busyq[i]) if (c >= busyq[i].lo && c <= busyq[i].hi) return 1;
    return 0;
  endfunction

  // Monitor + behavioural BU/RAM: reads happen before writes of the same cycle,
  // like a RAM without read-during-write bypass.
  always @(negedge clk) begin
    rd_exp_t er;
    wr_exp_t ew;
    bu_res_t br;
    int a, b, w, tw, ed;
    if (!rst_n) begin
      chk("reset_outputs", all_outs(), 0);
    end else begin
      chk("busy", busy, busy_exp(cyc));
      if (rd_en) begin
        rd_cnt++;
        if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          er = rdq.pop_front();
          chk("rd_cycle", cyc, er.cyc);
          chk("rd_addr_u", rd_addr_u, er.u);
          chk("rd_addr_t", rd_addr_t, er.t);
          chk("zeta_addr", zeta_addr, er.z);
          chk("bu_mode", bu_mode, er.mode);
        end
        a = ram[rd_addr_u];
        b = ram[rd_addr_t];
        w = zt[zeta_addr];
        if (cur_op == 0) begin
          tw   = (w * b) % Q;
          br.u = (a + tw) % Q;
          br.t = (a - tw + Q) % Q;
        end else begin
          br.u = (a + b) % Q;
          br.t = (w * ((b - a + Q) % Q)) % Q;
        end
        buq.push_back(br);
      end
      if (wr_en) begin
        wr_cnt++;
        if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          ew = wrq.pop_front();
          chk("wr_cycle", cyc, ew.cyc);
          chk("wr_addr_u", wr_addr_u, ew.u);
          chk("wr_addr_t", wr_addr_t, ew.t);
        end
        if (buq.size() == 0) chk("wr_no_data", 1, 0);
        else begin
          br = buq.pop_front();
          ram[wr_addr_u] = br.u;
          ram[wr_addr_t] = br.t;
        end
      end
      if (done) begin
        done_cnt++;
        if (doneq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          ed = doneq.pop_front();
          chk("done_cycle", cyc, ed);
        end
      end
    end
  end

  // Expected schedule straight from the Kyber loop nests: layer s, block start
  // st, butterfly j; twiddle index k steps once per block.
  task automatic push_run(input int c0, input int o);
    int n;
    int k;
    rd_exp_t er;
    wr_exp_t ew;
    iv_t iv;
    n = 0;
    k = (o == 0) ? 1 : 127;
    for (int s = 0; s < 7; s++) begin
      int len;
      len = (o == 0) ? (128 >> s) : (2 << s);
      for (int st = 0; st < 256; st += 2 * len) begin
        int z;
        z = k;
        k = (o == 0) ? k + 1 : k - 1;
        for (int j = st; j < st + len; j++) begin
          er.cyc = c0 + 1 + (n / 128) * LAYER_CYC + (n % 128);
          er.u = j; er.t = j + len; er.z = z; er.mode = o;
          rdq.push_back(er);
          ew.cyc = er.cyc + PIPE; ew.u = j; ew.t = j + len;
          wrq.push_back(ew);
          n++;
        end
      end
    end
    doneq.push_back(c0 + RUN_CYC);
    iv.lo = c0 + 1;
    iv.hi = c0 + RUN_CYC;
    busyq.push_back(iv);
  endtask

  task automatic sw_ntt();
    int k;
    k = 1;
    for (int len = 128; len >= 2; len >>= 1)
      for (int st = 0; st < 256; st += 2 * len) begin
        int z;
        z = zt[k];
        k++;
        for (int j = st; j < st + len; j++) begin
          int t;
          t = (z * refp[j + len]) % Q;
          refp[j + len] = (refp[j] - t + Q) % Q;
          refp[j] = (refp[j] + t) % Q;
        end
      end
  endtask

  task automatic load_random();
    for (int i = 0; i < 256; i++) begin
      orig[i] = int'($urandom_range(Q - 1, 0));
      ram[i]  = orig[i];
      refp[i] = orig[i];
    end
  endtask

  task automatic cmp_ram(input string name);
    int nmis;
    nmis = 0;
    for (int i = 0; i < 256; i++) if (ram[i] != refp[i]) nmis++;
    chk(name, nmis, 0);
  endtask

  task automatic clear_counts();
    rd_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_run(input int o, output int c0);
    c0 = cyc;
    clear_counts();
    cur_op = o;
    push_run(c0, o);
    op = o[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 1'b0;
  endtask

  task automatic end_run(input int nr);
    chk("rd_left", rdq.size(), 0);
    chk("wr_left", wrq.size(), 0);
    chk("done_left", doneq.size(), 0);
    chk("done_count", done_cnt, nr);
    chk("rd_count", rd_cnt, 896 * nr);
    chk("wr_count", wr_cnt, 896 * nr);
    rdq.delete(); wrq.delete(); doneq.delete(); buq.delete(); busyq.delete();
  endtask

  task automatic pulse_start(input int c);
    wait_until(c);
    start = 1'b1;
    op = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // Twiddle ROM: zeta^brv7(k) with zeta = 17, a primitive 256th root mod q.
    for (int k = 0; k < 128; k++) begin
      int e, v;
      e = 0;
      for (int bt = 0; bt < 7; bt++) e |= ((k >> bt) & 1) << (6 - bt);
      v = 1;
      for (int m = 0; m < e; m++) v = (v * 17) % Q;
      zt[k] = v;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // NTT with stray start pulses (including one in the done cycle)
    load_random();
    sw_ntt();
    start_run(0, c0);
    pulse_start(c0 + 5);
    pulse_start(c0 + 500);
    pulse_start(c0 + int'($urandom_range(600, 900)));
    pulse_start(c0 + RUN_CYC);
    wait_until(c0 + RUN_CYC + 3);
    end_run(1);
    cmp_ram("ntt_result");

    // INTT on the NTT output restores 128 * original
    for (int i = 0; i < 256; i++) refp[i] = (orig[i] * 128) % Q;
    start_run(1, c0);
    wait_until(c0 + RUN_CYC + 3);
    end_run(1);
    cmp_ram("intt_roundtrip");

    // start held high: second run accepted once back in IDLE
    load_random();
    sw_ntt();
    sw_ntt();
    clear_counts();
    cur_op = 0;
    c0 = cyc;
    push_run(c0, 0);
    push_run(c0 + RUN_CYC + 1, 0);
    op = 1'b0;
    start = 1'b1;
    wait_until(c0 + RUN_CYC + 2);
    start = 1'b0;
    wait_until(c0 + 2 * (RUN_CYC + 1) + 3);
    end_run(2);
    cmp_ram("held_start_result");

    // Asynchronous reset mid-run
    load_random();
    start_run(0, c0);
    wait_until(c0 + 300);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", all_outs(), 0);
    rdq.delete(); wrq.delete(); doneq.delete(); buq.delete(); busyq.delete();
    clear_counts();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("wr_after_reset", wr_cnt, 0);
    chk("rd_after_reset", rd_cnt, 0);

    load_random();
    sw_ntt();
    start_run(0, c0);
    wait_until(c0 + RUN_CYC + 3);
    end_run(1);
    cmp_ram("ntt_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
